store_buffer: RTL
=================

# store_buffer

Posted-store queue between the execute/memory pipeline register and the data memory (DM). Accepts byte-enabled word stores from the pipeline, merges back-to-back stores to the same word, and drains them to DM one word per cycle through a valid/ready port. Loads compare their address against every pending entry, and the block returns forwarded bytes plus a byte mask so the memory stage can combine them with DM read data.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low: 0 on a rising clk edge resets the block.
- st_valid  input  1  a store is presented.
- st_addr  input  32  byte address; bits [1:0] are ignored and the word address is st_addr[31:2].
- st_data  input  32  lane-aligned store data (byte k in bits [8k+7:8k]).
- st_be  input  4  byte enables; at least one bit is set when st_valid=1.
- st_pc  input  32  PC of the store instruction, kept for DM trace output.
- st_ready  output  1  the store is accepted this cycle when st_valid=1.
- ld_addr  input  32  load address; only [31:2] is compared.
- ld_fwd_data  output  32  forwarded bytes, lane-aligned; 0 in lanes not forwarded.
- ld_fwd_mask  output  4  lanes supplied by the buffer.
- dm_wvalid  output  1  the head entry is presented to DM.
- dm_waddr  output  32  word address of the head entry as {addr[31:2], 2'b00}.
- dm_wdata  output  32  head data; lanes outside dm_wbe are 0.
- dm_wbe  output  4  head byte enables.
- dm_wpc  output  32  PC of the most recent store merged into the head entry.
- dm_wready  input  1  DM accepts the head entry this cycle.
- empty  output  1  no entries pending.

## Operation
- **Storage.** Circular FIFO of DEPTH entries. Each entry holds {waddr[29:0], data[31:0], be[3:0], pc[31:0]}. State is tracked by head and tail pointers (PTR_W bits, wrapping modulo DEPTH) and a count (PTR_W+1 bits).
- **Ready.** st_ready = (count != DEPTH). It is a function of registered state only and does not depend on dm_wready.
- **Accept.** A store is accepted when st_valid && st_ready.
- **Merge.** An accepted store merges into the youngest entry (tail-1) when all of these hold:
  - count != 0;
  - the youngest entry's waddr equals st_addr[31:2];
  - the youngest entry is not being popped this cycle (that is, not count==1 && dm_wvalid && dm_wready).
- **Merge effect.** For lanes with st_be set, the data byte is replaced; be |= st_be; pc = st_pc. Count and tail are unchanged.
- **No merge.** The store is written at tail with data masked by st_be; tail increments and count increments.
- **Pop.** When dm_wvalid && dm_wready, head increments and count decrements.
- **Push and pop together.** Count is unchanged. Both actions occur even when count==1.
- **Drain outputs.** dm_wvalid = (count != 0). dm_w* reflect the head entry. While dm_wvalid=1 and dm_wready=0, all dm_w* stay stable.
- **Load forwarding.** Combinational from registered entries only; a store accepted in the same cycle is not visible. For each lane k, the buffer selects the youngest valid entry whose waddr matches and whose be[k]=1:
  - ld_fwd_mask[k] = 1 and that entry's byte appears in lane k;
  - if no entry qualifies, lane k has mask 0 and data 0.
- **Address range.** Full 30-bit word addresses are compared; there is no range check. DM range checking applies downstream.

## Timing
- **Reset** (reset=0 at a posedge): head=tail=count=0, so empty=1, st_ready=1, dm_wvalid=0, and ld_fwd_mask=0. dm_waddr, dm_wdata, dm_wbe and dm_wpc read as 0 because entry storage is also cleared.
- **Reset mid-operation.** All pending stores are discarded and none reach DM. A store presented in the reset cycle is not accepted.
- **Latency.** A store accepted at edge N appears on dm_w* and in forwarding from cycle N+1. If the buffer was empty, the minimum store-to-DM-write time is 1 cycle plus DM's edge.
- **Throughput.** One accept and one drain per cycle, sustained.
- **Full.** At count==DEPTH, st_ready=0 even if dm_wready=1 in that cycle. A merge-eligible store is also refused. st_ready returns to 1 in the cycle after a pop.
- **Pointer wrap.** Pointers wrap modulo DEPTH. Entry order is preserved across the wrap.

## Test plan
- **Empty-buffer store.** After reset, store addr 0x00001004, data 0xDEADBEEF, be 4'hF, dm_wready=1. Next cycle: dm_wvalid=1, dm_waddr=0x00001004, dm_wdata=0xDEADBEEF. Cycle after: empty=1.
- **Merge.** With dm_wready=0, store be 4'b0010 data 0x0000AB00 to 0x00002001, then be 4'b1000 data 0xCD000000 to 0x00002003. Result: count=1, dm_wbe=4'b1010, dm_wdata=0xCD00AB00, dm_wpc = the second PC.
- **Full/backpressure.** With dm_wready=0, send 5 stores to distinct words. The first 4 are accepted and st_ready=0 on the 5th. Raise dm_wready for one cycle: st_ready=1 the next cycle, and drain order equals accept order.
- **Forwarding priority.** Pending entries: 0x3000 be 4'hF 0x11223344 (older) and 0x3000... block with dm_wready=0 via a different word between them so they don't merge: 0x3000 be 4'hF 0x11223344, 0x4000 be 4'hF, 0x3000 be 4'b0001 0x00000099. ld_addr=0x3002 gives ld_fwd_mask=4'hF and ld_fwd_data=0x11223399.
- **Same-cycle push/pop at count==1.** The entry is popped while a store to the same word is accepted. The store is not merged: it becomes a new entry, count stays 1, and the new data appears on dm_w* the next cycle.
- **Reset mid-drain.** With 3 entries pending, assert reset=0 for one cycle. Afterwards empty=1, dm_wvalid=0, no further DM writes occur, and ld_fwd_mask=0.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-store queue: merges back-to-back stores to the same word, drains one word per
// cycle to data memory, and forwards pending bytes to loads per lane.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_fwd_data,
  output logic [3:0]  ld_fwd_mask,
  output logic        dm_wvalid,
  output logic [31:0] dm_waddr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wbe,
  output logic [31:0] dm_wpc,
  input  logic        dm_wready,
  output logic        empty
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [29:0]      waddr_q [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, youngest;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop, accept, merge, push;
  logic [31:0]      st_lane_mask;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready  = (count_q != CNT_FULL);
  assign empty     = (count_q == '0);
  assign dm_wvalid = !empty;
  assign dm_waddr  = {waddr_q[head_q], 2'b00};
  assign dm_wdata  = data_q[head_q];
  assign dm_wbe    = be_q[head_q];
  assign dm_wpc    = pc_q[head_q];

  assign youngest = tail_q - PTR_ONE;
  assign pop      = dm_wvalid && dm_wready;
  assign accept   = st_valid && st_ready;
  // The youngest entry cannot absorb a store while it is leaving the buffer.
  assign merge    = accept && !empty && (waddr_q[youngest] == st_addr[31:2])
                    && !((count_q == CNT_ONE) && pop);
  assign push     = accept && !merge;

  for (genvar gi = 0; gi < 4; gi++) begin : g_st_lane
    assign st_lane_mask[8*gi +: 8] = {8{st_be[gi]}};
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PTR_ONE;
    if (push) tail_d = tail_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (merge) begin
        data_q[youngest] <= (data_q[youngest] & ~st_lane_mask) | (st_data & st_lane_mask);
        be_q[youngest]   <= be_q[youngest] | st_be;
        pc_q[youngest]   <= st_pc;
      end else if (push) begin
        waddr_q[tail_q] <= st_addr[31:2];
        data_q[tail_q]  <= st_data & st_lane_mask;
        be_q[tail_q]    <= st_be;
        pc_q[tail_q]    <= st_pc;
      end
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins each lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_lane
    logic             lane_hit;
    logic [7:0]       lane_byte;
    logic [PTR_W-1:0] idx;
    always_comb begin
      lane_hit  = 1'b0;
      lane_byte = '0;
      idx       = head_q;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if (((PTR_W+1)'(i) < count_q) && (waddr_q[idx] == ld_addr[31:2]) && be_q[idx][gi]) begin
          lane_hit  = 1'b1;
          lane_byte = data_q[idx][8*gi +: 8];
        end
      end
    end
    assign ld_fwd_mask[gi]         = lane_hit;
    assign ld_fwd_data[8*gi +: 8] = lane_byte;
  end

endmodule
